sa_tile_sched: RTL and testbench
================================

Name: sa_tile_sched

Overview:
- Sequences the systolic-array core over a tiled matrix job, so software issues one command instead of one per tile.
- Sits between the ICB register file (CONFIG/CALCBASE/STAT) and the SA core.
- Walks row tiles × column tiles in row-major order, drives per-tile base addresses, and pulses SA start.
- Waits for SA done on each tile, with a watchdog, and reports job completion or error.

Parameters:
ADDR_W, 12, width of row/col SRAM base addresses (matches CALCBASE fields)
OADDR_W, 13, width of output-buffer address
CNT_W, 8, width of tile counters
TMO_W, 16, watchdog width; timeout after 2^TMO_W-1 cycles in WAIT

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
cfg_start  in  1  single-cycle job start request
cfg_abort  in  1  abort current job
cfg_row_base  in  ADDR_W  row SRAM base of tile (0,*)
cfg_col_base  in  ADDR_W  col SRAM base of tile (*,0)
cfg_row_stride  in  ADDR_W  row-address increment per row tile
cfg_col_stride  in  ADDR_W  col-address increment per col tile
cfg_out_base  in  OADDR_W  output address of tile 0
cfg_out_stride  in  OADDR_W  output-address increment per tile (linear tile index)
cfg_row_tiles  in  CNT_W  number of row tiles (0 illegal)
cfg_col_tiles  in  CNT_W  number of col tiles (0 illegal)
sa_start  out  1  one-cycle start pulse to SA core
sa_done  in  1  SA tile-complete pulse
calc_row_addr  out  ADDR_W  current tile row base to SA SRAM address adder
calc_col_addr  out  ADDR_W  current tile col base
out_addr  out  OADDR_W  current tile output address
tile_row_idx  out  CNT_W  current row tile index
tile_col_idx  out  CNT_W  current col tile index
busy  out  1  job in progress
done  out  1  sticky job-complete flag
done_pulse  out  1  one-cycle completion pulse
err  out  1  sticky error (zero tile count or watchdog)

Behaviour:
- Reset: state IDLE; every output 0.
- States: IDLE, START, WAIT, NEXT, FIN.
- IDLE, cfg_start=1, both tile counts ≠ 0:
  - Latch all cfg_* inputs.
  - At the same edge: calc_row_addr=row_base, calc_col_addr=col_base, out_addr=out_base, indices=0.
  - Clear done and err; go to START.
- IDLE, cfg_start=1, either tile count = 0: set err, stay IDLE, no sa_start.
- START: sa_start=1 for exactly this cycle; clear watchdog; go to WAIT.
- WAIT:
  - sa_done=1 → NEXT.
  - Watchdog reaches 2^TMO_W-1 → set err, go to IDLE with busy=0 and done unchanged.
  - sa_done is ignored in every other state.
- NEXT (one cycle):
  - If col_idx < col_tiles-1: col_idx+1; calc_col_addr += col_stride; out_addr += out_stride; → START.
  - Else if row_idx < row_tiles-1: row_idx+1; col_idx=0; calc_row_addr += row_stride; calc_col_addr=col_base; out_addr += out_stride; → START.
  - Else → FIN.
- FIN: done_pulse=1 for one cycle; done set (sticky); → IDLE.
- busy=1 in START/WAIT/NEXT/FIN; 0 in IDLE.
- Timing:
  - First sa_start occurs 1 cycle after the cfg_start edge.
  - After sa_done in cycle t: NEXT in t+1, next sa_start in t+2.
  - Total job = tiles × (SA latency + 3) + 1 cycles.
- Address outputs are registered and stable from START through NEXT of each tile.
- Arithmetic: all address sums are modulo 2^width; wrap silently, no error.
- cfg_start while busy: ignored; latched config is unaffected by cfg_* changes mid-job.
- cfg_abort: from any non-IDLE state → IDLE next edge; busy=0; sa_start never asserted that cycle; done/err unchanged.
- Simultaneous cfg_abort and cfg_start in IDLE: abort wins, no job starts.
- Simultaneous sa_done and watchdog expiry in WAIT: sa_done wins.
- rst_n asserted mid-job: immediate return to reset values.

Decomposition:
- Shared package acc_pkg:
  - state enum sched_state_t {IDLE, START, WAIT, NEXT, FIN};
  - ADDR_W/OADDR_W/CNT_W defaults;
  - CONFIG/STAT bit-position constants reused by the register file.
- One sub-module, sa_tile_addr_gen: holds the tile counters and the three address accumulators, with init/step controls and a last_tile flag. The FSM stays in sa_tile_sched.

Test Plan:
- 2×3 tiles, row_base=0x010, row_stride=0x040, col_base=0x100, col_stride=0x020, out_base=0, out_stride=4, SA model done 5 cycles after start → 6 sa_start pulses.
  - (row,col) addresses: (0x010,0x100), (0x010,0x120), (0x010,0x140), (0x050,0x100), (0x050,0x120), (0x050,0x140).
  - out_addr = 0, 4, 8, 12, 16, 20.
  - One done_pulse, done=1, busy=0.
- cfg_row_tiles=0, cfg_start → err=1, no sa_start, busy stays 0.
- SA model never returns done, TMO_W=4 → err=1 exactly 15 cycles after WAIT entry; state IDLE; a new job then runs normally and clears err.
- 4×4 job, cfg_abort during 3rd WAIT → busy=0 next cycle; no further sa_start; done=0; sa_done arriving afterwards ignored.
- cfg_start pulsed again mid-job, and cfg_col_stride changed mid-job → ignored; addresses follow the originally latched config.
- row_base=0xFF0, row_stride=0x020, 2×1 tiles → second calc_row_addr=0x010 (wrap), no err.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared accelerator definitions: scheduler state encoding, default widths and
// CONFIG/STAT register bit positions used by the register file.
package acc_pkg;

    localparam int ADDR_W_DEF  = 12;
    localparam int OADDR_W_DEF = 13;
    localparam int CNT_W_DEF   = 8;
    localparam int TMO_W_DEF   = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        NEXT,
        FIN
    } sched_state_t;

    // CONFIG register
    localparam int CFG_START_BIT = 0;
    localparam int CFG_ABORT_BIT = 1;

    // STAT register
    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_DONE_BIT = 1;
    localparam int STAT_ERR_BIT  = 2;

endpackage

// File: rtl/sa_tile_addr_gen.sv
// Tile walker: latches the job geometry on init and advances row-major tile
// indices plus the row/col/output address accumulators on each step.
module sa_tile_addr_gen
    import acc_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int OADDR_W = OADDR_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               init,
    input  logic               step,
    input  logic [ADDR_W-1:0]  cfg_row_base,
    input  logic [ADDR_W-1:0]  cfg_col_base,
    input  logic [ADDR_W-1:0]  cfg_row_stride,
    input  logic [ADDR_W-1:0]  cfg_col_stride,
    input  logic [OADDR_W-1:0] cfg_out_base,
    input  logic [OADDR_W-1:0] cfg_out_stride,
    input  logic [CNT_W-1:0]   cfg_row_tiles,
    input  logic [CNT_W-1:0]   cfg_col_tiles,
    output logic [ADDR_W-1:0]  row_addr,
    output logic [ADDR_W-1:0]  col_addr,
    output logic [OADDR_W-1:0] out_addr,
    output logic [CNT_W-1:0]   row_idx,
    output logic [CNT_W-1:0]   col_idx,
    output logic               last_tile
);

    logic [ADDR_W-1:0]  col_base_q, row_stride_q, col_stride_q;
    logic [OADDR_W-1:0] out_stride_q;
    logic [CNT_W-1:0]   row_last_q, col_last_q;
    logic               last_col, last_row;

    assign last_col  = (col_idx == col_last_q);
    assign last_row  = (row_idx == row_last_q);
    assign last_tile = last_col && last_row;

    // Sums wrap modulo 2^width by construction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_addr     <= '0;
            col_addr     <= '0;
            out_addr     <= '0;
            row_idx      <= '0;
            col_idx      <= '0;
            col_base_q   <= '0;
            row_stride_q <= '0;
            col_stride_q <= '0;
            out_stride_q <= '0;
            row_last_q   <= '0;
            col_last_q   <= '0;
        end else if (init) begin
            row_addr     <= cfg_row_base;
            col_addr     <= cfg_col_base;
            out_addr     <= cfg_out_base;
            row_idx      <= '0;
            col_idx      <= '0;
            col_base_q   <= cfg_col_base;
            row_stride_q <= cfg_row_stride;
            col_stride_q <= cfg_col_stride;
            out_stride_q <= cfg_out_stride;
            row_last_q   <= cfg_row_tiles - 1'b1;
            col_last_q   <= cfg_col_tiles - 1'b1;
        end else if (step) begin
            if (!last_col) begin
                col_idx  <= col_idx + 1'b1;
                col_addr <= col_addr + col_stride_q;
                out_addr <= out_addr + out_stride_q;
            end else if (!last_row) begin
                row_idx  <= row_idx + 1'b1;
                col_idx  <= '0;
                row_addr <= row_addr + row_stride_q;
                col_addr <= col_base_q;
                out_addr <= out_addr + out_stride_q;
            end
        end
    end

endmodule

// File: rtl/sa_tile_sched.sv
// Tiled-job sequencer for the systolic-array core: one software command walks
// every tile, pulses SA start per tile and guards each tile with a watchdog.
module sa_tile_sched
    import acc_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int OADDR_W = OADDR_W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TMO_W   = TMO_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_start,
    input  logic               cfg_abort,
    input  logic [ADDR_W-1:0]  cfg_row_base,
    input  logic [ADDR_W-1:0]  cfg_col_base,
    input  logic [ADDR_W-1:0]  cfg_row_stride,
    input  logic [ADDR_W-1:0]  cfg_col_stride,
    input  logic [OADDR_W-1:0] cfg_out_base,
    input  logic [OADDR_W-1:0] cfg_out_stride,
    input  logic [CNT_W-1:0]   cfg_row_tiles,
    input  logic [CNT_W-1:0]   cfg_col_tiles,
    output logic               sa_start,
    input  logic               sa_done,
    output logic [ADDR_W-1:0]  calc_row_addr,
    output logic [ADDR_W-1:0]  calc_col_addr,
    output logic [OADDR_W-1:0] out_addr,
    output logic [CNT_W-1:0]   tile_row_idx,
    output logic [CNT_W-1:0]   tile_col_idx,
    output logic               busy,
    output logic               done,
    output logic               done_pulse,
    output logic               err
);

    // Expiry is flagged on the edge the counter would reach all-ones.
    localparam logic [TMO_W-1:0] WDOG_LIM = {TMO_W{1'b1}} - 1'b1;

    sched_state_t     state;
    logic [TMO_W-1:0] wdog;
    logic             cnt_ok, launch, step, last_tile;

    assign cnt_ok = (cfg_row_tiles != '0) && (cfg_col_tiles != '0);
    assign launch = (state == IDLE) && cfg_start && !cfg_abort && cnt_ok;
    assign step   = (state == NEXT) && !cfg_abort;

    sa_tile_addr_gen #(
        .ADDR_W  (ADDR_W),
        .OADDR_W (OADDR_W),
        .CNT_W   (CNT_W)
    ) u_addr_gen (
        .clk            (clk),
        .rst_n          (rst_n),
        .init           (launch),
        .step           (step),
        .cfg_row_base   (cfg_row_base),
        .cfg_col_base   (cfg_col_base),
        .cfg_row_stride (cfg_row_stride),
        .cfg_col_stride (cfg_col_stride),
        .cfg_out_base   (cfg_out_base),
        .cfg_out_stride (cfg_out_stride),
        .cfg_row_tiles  (cfg_row_tiles),
        .cfg_col_tiles  (cfg_col_tiles),
        .row_addr       (calc_row_addr),
        .col_addr       (calc_col_addr),
        .out_addr       (out_addr),
        .row_idx        (tile_row_idx),
        .col_idx        (tile_col_idx),
        .last_tile      (last_tile)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wdog       <= '0;
            sa_start   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            done_pulse <= 1'b0;
            err        <= 1'b0;
        end else begin
            sa_start   <= 1'b0;
            done_pulse <= 1'b0;
            if (cfg_abort && state != IDLE) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (launch) begin
                            state    <= START;
                            busy     <= 1'b1;
                            sa_start <= 1'b1;
                            done     <= 1'b0;
                            err      <= 1'b0;
                        end else if (cfg_start && !cfg_abort) begin
                            err <= 1'b1;
                        end
                    end
                    START: begin
                        wdog  <= '0;
                        state <= WAIT;
                    end
                    WAIT: begin
                        // sa_done takes priority over a coincident expiry
                        if (sa_done) begin
                            state <= NEXT;
                        end else if (wdog == WDOG_LIM) begin
                            err   <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            wdog <= wdog + 1'b1;
                        end
                    end
                    NEXT: begin
                        if (last_tile) begin
                            state      <= FIN;
                            done_pulse <= 1'b1;
                            done       <= 1'b1;
                        end else begin
                            state    <= START;
                            sa_start <= 1'b1;
                        end
                    end
                    FIN: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sa_tile_sched.sv
// Directed bench for sa_tile_sched with a fixed-latency SA core model that
// logs the tile addresses presented at every sa_start.
module tb_sa_tile_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_start = 1'b0, cfg_abort = 1'b0;
    logic [11:0] cfg_row_base = '0, cfg_col_base = '0, cfg_row_stride = '0, cfg_col_stride = '0;
    logic [12:0] cfg_out_base = '0, cfg_out_stride = '0;
    logic [7:0]  cfg_row_tiles = '0, cfg_col_tiles = '0;
    logic        sa_start, sa_done = 1'b0;
    logic [11:0] calc_row_addr, calc_col_addr;
    logic [12:0] out_addr;
    logic [7:0]  tile_row_idx, tile_col_idx;
    logic        busy, done, done_pulse, err;

    int checks = 0, failures = 0;
    int nstart = 0, npulse = 0, sa_cnt = 0, cyc = 0, last_done_cyc = -1;
    bit sa_en = 1'b1;
    logic [11:0] rq[$], cq[$];
    logic [12:0] oq[$];
    int gaps[$];

    always #5 clk = ~clk;

    sa_tile_sched #(.TMO_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
        .cfg_row_base(cfg_row_base), .cfg_col_base(cfg_col_base),
        .cfg_row_stride(cfg_row_stride), .cfg_col_stride(cfg_col_stride),
        .cfg_out_base(cfg_out_base), .cfg_out_stride(cfg_out_stride),
        .cfg_row_tiles(cfg_row_tiles), .cfg_col_tiles(cfg_col_tiles),
        .sa_start(sa_start), .sa_done(sa_done),
        .calc_row_addr(calc_row_addr), .calc_col_addr(calc_col_addr), .out_addr(out_addr),
        .tile_row_idx(tile_row_idx), .tile_col_idx(tile_col_idx),
        .busy(busy), .done(done), .done_pulse(done_pulse), .err(err)
    );

    // SA core model: done pulse five edges after a start, unless disabled
    always @(posedge clk) begin
        cyc = cyc + 1;
        sa_done <= 1'b0;
        if (sa_done) last_done_cyc = cyc;
        if (done_pulse) npulse = npulse + 1;
        if (sa_start) begin
            nstart = nstart + 1;
            rq.push_back(calc_row_addr);
            cq.push_back(calc_col_addr);
            oq.push_back(out_addr);
            if (last_done_cyc >= 0) gaps.push_back(cyc - last_done_cyc);
            last_done_cyc = -1;
            sa_cnt = sa_en ? 5 : 0;
        end else if (sa_cnt > 0) begin
            sa_cnt = sa_cnt - 1;
            if (sa_cnt == 0) sa_done <= 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        rq.delete(); cq.delete(); oq.delete(); gaps.delete();
        nstart = 0; npulse = 0; last_done_cyc = -1;
    endtask

    task automatic job(input logic [11:0] rb, rs, cb, cs, input logic [12:0] ob, os,
                       input logic [7:0] rt, ct);
        clear_log();
        cfg_row_base = rb; cfg_row_stride = rs; cfg_col_base = cb; cfg_col_stride = cs;
        cfg_out_base = ob; cfg_out_stride = os; cfg_row_tiles = rt; cfg_col_tiles = ct;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic run_done(input int bound);
        int n = 0;
        while (!done && n < bound) begin
            tick();
            n++;
        end
        check("job_done_in_budget", done, 1);
    endtask

    initial begin
        logic [11:0] exp_r[6] = '{12'h010, 12'h010, 12'h010, 12'h050, 12'h050, 12'h050};
        logic [11:0] exp_c[6] = '{12'h100, 12'h120, 12'h140, 12'h100, 12'h120, 12'h140};
        int n;

        // reset state
        repeat (2) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_sa_start", sa_start, 0);
        check("rst_addrs", {calc_row_addr, calc_col_addr}, 0);
        rst_n = 1'b1;
        tick();

        // 2x3 job
        job(12'h010, 12'h040, 12'h100, 12'h020, 13'd0, 13'd4, 8'd2, 8'd3);
        check("j1_first_sa_start", sa_start, 1);
        check("j1_busy", busy, 1);
        check("j1_init_addrs", {calc_row_addr, calc_col_addr}, {12'h010, 12'h100});
        run_done(200);
        check("j1_done_pulse", done_pulse, 1);
        tick();
        check("j1_busy_after", busy, 0);
        check("j1_done_sticky", done, 1);
        check("j1_npulse", npulse, 1);
        check("j1_nstart", nstart, 6);
        check("j1_err", err, 0);
        for (int i = 0; i < 6 && i < rq.size(); i++) begin
            check($sformatf("j1_row_addr[%0d]", i), rq[i], exp_r[i]);
            check($sformatf("j1_col_addr[%0d]", i), cq[i], exp_c[i]);
            check($sformatf("j1_out_addr[%0d]", i), oq[i], 4 * i);
        end
        for (int i = 0; i < gaps.size(); i++)
            check($sformatf("j1_done_to_start[%0d]", i), gaps[i], 2);
        check("j1_ngaps", gaps.size(), 5);

        // zero tile count
        job(12'h0, 12'h0, 12'h0, 12'h0, 13'd0, 13'd0, 8'd0, 8'd3);
        check("zero_err", err, 1);
        check("zero_busy", busy, 0);
        repeat (3) tick();
        check("zero_no_start", nstart, 0);
        check("zero_busy_later", busy, 0);

        // watchdog: SA never answers
        sa_en = 1'b0;
        job(12'h0, 12'h0, 12'h0, 12'h0, 13'd0, 13'd0, 8'd1, 8'd1);
        check("wd_start_clears_err", err, 0);
        tick();                       // START -> WAIT edge
        repeat (14) tick();
        check("wd_err_not_yet", err, 0);
        check("wd_busy_not_yet", busy, 1);
        tick();
        check("wd_err_at_15", err, 1);
        check("wd_busy_cleared", busy, 0);
        check("wd_done_unchanged", done, 0);
        sa_en = 1'b1;
        job(12'h0, 12'h0, 12'h0, 12'h0, 13'd0, 13'd0, 8'd1, 8'd2);
        check("wd_recover_err_cleared", err, 0);
        run_done(100);
        check("wd_recover_nstart", nstart, 2);

        // abort and start together in IDLE
        repeat (2) tick();
        clear_log();
        cfg_row_tiles = 8'd1; cfg_col_tiles = 8'd1;
        cfg_start = 1'b1; cfg_abort = 1'b1;
        tick();
        cfg_start = 1'b0; cfg_abort = 1'b0;
        check("abort_wins_busy", busy, 0);
        check("abort_wins_sa_start", sa_start, 0);
        tick();
        check("abort_wins_nstart", nstart, 0);

        // 4x4 job aborted during 3rd WAIT
        job(12'h000, 12'h010, 12'h000, 12'h010, 13'd0, 13'd1, 8'd4, 8'd4);
        n = 0;
        while (nstart < 3 && n < 100) begin
            tick();
            n++;
        end
        check("ab_reached_third", nstart, 3);
        tick();
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        check("ab_busy", busy, 0);
        check("ab_sa_start", sa_start, 0);
        repeat (20) tick();
        check("ab_no_more_starts", nstart, 3);
        check("ab_busy_later", busy, 0);
        check("ab_done", done, 0);
        check("ab_err", err, 0);

        // config changes and restart mid-job are ignored
        job(12'h300, 12'h000, 12'h200, 12'h010, 13'd100, 13'd8, 8'd1, 8'd3);
        cfg_col_stride = 12'h300;
        cfg_col_base   = 12'h555;
        repeat (3) tick();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        run_done(100);
        tick();
        check("mid_nstart", nstart, 3);
        check("mid_busy_after", busy, 0);
        for (int i = 0; i < 3 && i < cq.size(); i++) begin
            check($sformatf("mid_col_addr[%0d]", i), cq[i], 12'h200 + 12'h010 * i);
            check($sformatf("mid_out_addr[%0d]", i), oq[i], 100 + 8 * i);
        end

        // row address wrap
        job(12'hFF0, 12'h020, 12'h000, 12'h000, 13'd0, 13'd1, 8'd2, 8'd1);
        run_done(100);
        tick();
        check("wrap_nstart", nstart, 2);
        if (rq.size() == 2) begin
            check("wrap_row0", rq[0], 12'hFF0);
            check("wrap_row1", rq[1], 12'h010);
        end
        check("wrap_err", err, 0);

        // reset mid-job
        job(12'h0, 12'h0, 12'h0, 12'h0, 13'd0, 13'd0, 8'd2, 8'd2);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
